ahb_sim_ctrl_mon: RTL

- Parametrised, synthesizable simulation-control monitor. Successor to the bench-level finish logic.
- Passively snoops the CPU AHB-Lite master bus and decodes mailbox writes into pass/fail/character events.
- Buffers console characters in a FIFO with a valid/ready drain port.
- Runs a multi-lane retire watchdog and a global cycle timeout. Sits beside the SoC top; its outputs drive the bench finish/print logic or an emulation status register.

---
 rtl/ahb_sim_ctrl_mon_if.sv | 14 +
 rtl/ahb_sim_ctrl_mon.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/ahb_sim_ctrl_mon_if.sv
// AHB-Lite snoop bundle: the bus master drives it, the simulation-control monitor observes it.
interface ahb_sim_ctrl_mon_if #(
    parameter int unsigned HADDR_W = 32,
    parameter int unsigned HDATA_W = 32
);
    logic [1:0]         htrans;
    logic [HADDR_W-1:0] haddr;
    logic               hwrite;
    logic [HDATA_W-1:0] hwdata;
    logic               hready;

    modport master (output htrans, haddr, hwrite, hwdata, hready);
    modport slave  (input  htrans, haddr, hwrite, hwdata, hready);
endinterface

// File: rtl/ahb_sim_ctrl_mon.sv
// Simulation-control monitor: decodes AHB mailbox writes into pass/fail/console events,
// buffers console characters and runs the retire watchdog and global cycle timeout.
module ahb_sim_ctrl_mon #(
    parameter int unsigned        HADDR_W    = 32,
    parameter int unsigned        HDATA_W    = 32,
    parameter logic [HADDR_W-1:0] MBOX_ADDR  = 32'h6000fff8,
    parameter logic [HDATA_W-1:0] PASS_CODE0 = 32'h00000fff,
    parameter logic [HDATA_W-1:0] PASS_CODE1 = 32'hffff0000,
    parameter logic [HDATA_W-1:0] FAIL_CODE0 = 32'h00000eee,
    parameter logic [HDATA_W-1:0] FAIL_CODE1 = 32'heeee0000,
    parameter int unsigned        RET_LANES  = 1,
    parameter int unsigned        WDOG_WIN   = 5000,
    parameter int unsigned        MAX_CYCLES = 0,
    parameter int unsigned        FIFO_DEPTH = 16,
    parameter int unsigned        CNT_W      = 32
) (
    input  logic                 clk,
    input  logic                 rst_b,
    ahb_sim_ctrl_mon_if.slave    bus,
    input  logic [RET_LANES-1:0] retire,
    output logic [7:0]           chr_data,
    output logic                 chr_valid,
    input  logic                 chr_ready,
    output logic                 chr_ovf,
    output logic                 done,
    output logic [2:0]           status,
    output logic [CNT_W-1:0]     cycle_cnt,
    output logic [CNT_W-1:0]     retire_total
);

    typedef enum logic [2:0] {
        ST_RUN     = 3'd0,
        ST_PASS    = 3'd1,
        ST_FAIL    = 3'd2,
        ST_HANG    = 3'd3,
        ST_TIMEOUT = 3'd4
    } state_t;

    localparam int unsigned POP_W = $clog2(RET_LANES + 1);
    localparam int unsigned WIN_W = (WDOG_WIN > 1) ? $clog2(WDOG_WIN) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

    state_t state_q, state_d;
    logic   running;
    assign running = (state_q == ST_RUN);

    // Address-phase capture; held across data-phase wait states.
    logic ap_valid;
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b)          ap_valid <= 1'b0;
        else if (bus.hready) ap_valid <= bus.htrans[1] && bus.hwrite && (bus.haddr == MBOX_ADDR);
    end

    logic mb_fire, is_pass, is_fail, push;
    assign mb_fire = ap_valid && bus.hready && running;
    assign is_pass = (bus.hwdata == PASS_CODE0) || (bus.hwdata == PASS_CODE1);
    assign is_fail = (bus.hwdata == FAIL_CODE0) || (bus.hwdata == FAIL_CODE1);
    assign push    = mb_fire && !is_pass && !is_fail;

    logic [POP_W-1:0] ret_pop;
    always_comb begin
        ret_pop = '0;
        for (int unsigned i = 0; i < RET_LANES; i++) ret_pop = ret_pop + POP_W'(retire[i]);
    end

    logic [CNT_W:0] ret_sum, cyc_inc;
    assign ret_sum = {1'b0, retire_total} + (CNT_W+1)'(ret_pop);
    assign cyc_inc = {1'b0, cycle_cnt} + (CNT_W+1)'(1);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            retire_total <= '0;
            cycle_cnt    <= '0;
        end else begin
            retire_total <= ret_sum[CNT_W] ? '1 : ret_sum[CNT_W-1:0];
            if (running && !cyc_inc[CNT_W]) cycle_cnt <= cyc_inc[CNT_W-1:0];
        end
    end

    logic timeout;
    assign timeout = (MAX_CYCLES != 0) && (cyc_inc == (CNT_W+1)'(MAX_CYCLES));

    // Window end counts retirements seen in that same cycle, hence the live |retire term.
    logic [WIN_W-1:0] win_cnt;
    logic             win_seen, win_end, hang;
    assign win_end = (win_cnt == WIN_W'(WDOG_WIN - 1));
    assign hang    = (WDOG_WIN != 0) && win_end && !win_seen && (retire == '0);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            win_cnt  <= '0;
            win_seen <= 1'b0;
        end else if (running) begin
            if (win_end) begin
                win_cnt  <= '0;
                win_seen <= 1'b0;
            end else begin
                win_cnt  <= win_cnt + WIN_W'(1);
                win_seen <= win_seen | (|retire);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_RUN) begin
            if (mb_fire && is_pass)      state_d = ST_PASS;
            else if (mb_fire && is_fail) state_d = ST_FAIL;
            else if (hang)               state_d = ST_HANG;
            else if (timeout)            state_d = ST_TIMEOUT;
        end
    end

    assign status = state_q;
    assign done   = (state_q != ST_RUN);

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             full, pop, push_ok;

    assign full    = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign pop     = chr_valid && chr_ready;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            chr_ovf <= 1'b0;
        end else begin
            if (push_ok)         wr_ptr  <= wr_ptr + PTR_W'(1);
            if (pop)             rd_ptr  <= rd_ptr + PTR_W'(1);
            if (push && !push_ok) chr_ovf <= 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= bus.hwdata[7:0];
    end

    assign chr_valid = (count != '0);
    assign chr_data  = chr_valid ? mem[rd_ptr] : '0;

endmodule
